lattice_bank_responder: RTL and testbench

- Memory-side responder for the streaming engine's 9-address / 8-lane request interface.
- Owns eight per-direction distribution banks of HPIXELS*VPIXELS 9-bit words each.
- Services per-lane reads, returning data after a fixed latency, and per-lane writes.
- Has an init sequencer that fills every bank with equilibrium weights before a simulation starts.

---
 rtl/lattice_bank_responder.sv | 153 +++++++++++++++
 tb/tb_lattice_bank_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lattice_bank_responder.sv
// Memory-side responder owning eight per-direction distribution banks.
// Services per-lane reads/writes and fills banks with equilibrium weights on init.
module lattice_bank_responder #(
  parameter int HPIXELS      = 205,
  parameter int VPIXELS      = 154,
  parameter int READ_LATENCY = 2,
  parameter int INIT_AXIS    = 57,
  parameter int INIT_DIAG    = 14,
  localparam int BRAM_DEPTH  = HPIXELS * VPIXELS,
  localparam int BRAM_SIZE   = $clog2(BRAM_DEPTH)
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      init_in,
  input  logic                      req_in,
  input  logic                      we_in,
  input  logic [8:0][BRAM_SIZE-1:0] addr_in,
  input  logic [7:0][8:0]           data_in,
  output logic [7:0][8:0]           data_out,
  output logic                      valid_out,
  output logic                      busy_out,
  output logic                      init_done_out
);

  typedef enum logic [1:0] {IDLE, INIT, SERVE} state_t;

  localparam int DLY = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
  localparam logic [BRAM_SIZE-1:0] LAST  = BRAM_SIZE'(BRAM_DEPTH - 1);
  localparam logic [BRAM_SIZE-1:0] LIMIT = BRAM_SIZE'(BRAM_DEPTH);

  state_t               state;
  logic [BRAM_SIZE-1:0] cnt;
  logic                 accept;
  logic                 wr_req;
  logic                 rd_req;
  logic                 rd_v;
  logic [DLY-1:0]       vdly;
  logic [7:0][8:0]      rd_word;
  logic [7:0][8:0]      dly [DLY];
  logic                 tail_v;
  logic [7:0][8:0]      tail_d;
  logic                 unused_rest_addr;

  assign unused_rest_addr = ^addr_in[0];

  // A request is taken in IDLE or SERVE unless init_in arrives with it.
  always_comb begin
    accept = 1'b0;
    if ((state == IDLE || state == SERVE) && !rst_in)
      accept = req_in & ~init_in;
    wr_req = accept & we_in;
    rd_req = accept & ~we_in;
  end

  for (genvar i = 0; i < 8; i++) begin : g_lane
    logic [8:0]           mem [BRAM_DEPTH];
    logic [BRAM_SIZE-1:0] a;
    logic                 in_range;
    logic                 we;
    logic [BRAM_SIZE-1:0] wa;
    logic [8:0]           wd;
    logic [8:0]           rd_q;

    assign a        = addr_in[i+1];
    assign in_range = a < LIMIT;
    assign rd_word[i] = rd_q;

    always_comb begin
      we = 1'b0;
      wa = a;
      wd = data_in[i];
      if (state == INIT) begin
        we = ~rst_in;
        wa = cnt;
        wd = (i < 4) ? 9'(INIT_AXIS) : 9'(INIT_DIAG);
      end else if (wr_req && in_range) begin
        we = 1'b1;
      end
    end

    // Bank contents survive reset; out-of-range reads return zero.
    always_ff @(posedge clk_in) begin
      if (we)
        mem[wa] <= wd;
      if (rd_req && in_range)
        rd_q <= mem[a];
      else
        rd_q <= '0;
    end
  end

  always_ff @(posedge clk_in) begin
    dly[0] <= rd_word;
    for (int unsigned k = 1; k < DLY; k++)
      dly[k] <= dly[k-1];
  end

  assign tail_v = (READ_LATENCY == 1) ? rd_v    : vdly[DLY-1];
  assign tail_d = (READ_LATENCY == 1) ? rd_word : dly[DLY-1];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state         <= IDLE;
      cnt           <= '0;
      busy_out      <= 1'b0;
      init_done_out <= 1'b0;
      rd_v          <= 1'b0;
      vdly          <= '0;
      valid_out     <= 1'b0;
      data_out      <= '0;
    end else begin
      init_done_out <= 1'b0;
      rd_v          <= rd_req;
      vdly[0]       <= rd_v;
      for (int unsigned k = 1; k < DLY; k++)
        vdly[k] <= vdly[k-1];
      valid_out <= tail_v;
      if (tail_v)
        data_out <= tail_d;

      case (state)
        IDLE: begin
          if (init_in) begin
            state    <= INIT;
            cnt      <= '0;
            busy_out <= 1'b1;
          end else if (req_in) begin
            state <= SERVE;
          end
        end
        INIT: begin
          if (cnt == LAST) begin
            state         <= SERVE;
            cnt           <= '0;
            busy_out      <= 1'b0;
            init_done_out <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SERVE: begin
          if (init_in) begin
            state    <= INIT;
            cnt      <= '0;
            busy_out <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lattice_bank_responder.sv
// Directed, table-driven bench for lattice_bank_responder with hand-computed
// expectations plus sequences for init, streaming, reset abort and re-init.
module tb_lattice_bank_responder;

  localparam int H  = 205;
  localparam int V  = 154;
  localparam int L  = 2;
  localparam int D  = H * V;
  localparam int AW = $clog2(D);

  logic                clk_in;
  logic                rst_in;
  logic                init_in;
  logic                req_in;
  logic                we_in;
  logic [8:0][AW-1:0]  addr_in;
  logic [7:0][8:0]     data_in;
  logic [7:0][8:0]     data_out;
  logic                valid_out;
  logic                busy_out;
  logic                init_done_out;

  int n_checks;
  int n_fail;

  typedef struct {
    logic               we;
    logic [8:0][AW-1:0] addr;
    logic [7:0][8:0]    data;
    logic [7:0][8:0]    exp;
  } vec_t;

  vec_t tbl [8];

  lattice_bank_responder #(
    .HPIXELS(H),
    .VPIXELS(V),
    .READ_LATENCY(L),
    .INIT_AXIS(57),
    .INIT_DIAG(14)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .init_in(init_in),
    .req_in(req_in),
    .we_in(we_in),
    .addr_in(addr_in),
    .data_in(data_in),
    .data_out(data_out),
    .valid_out(valid_out),
    .busy_out(busy_out),
    .init_done_out(init_done_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0][8:0] init_word();
    logic [7:0][8:0] w;
    for (int i = 0; i < 8; i++) w[i] = (i < 4) ? 9'd57 : 9'd14;
    return w;
  endfunction

  function automatic logic [8:0][AW-1:0] all_addr(input int a, input int rest);
    logic [8:0][AW-1:0] r;
    r[0] = AW'(rest);
    for (int j = 1; j < 9; j++) r[j] = AW'(a);
    return r;
  endfunction

  // Issue one request; for reads, verify the exact valid_out beat and data hold.
  task automatic apply(input vec_t v, input string name);
    req_in  = 1'b1;
    we_in   = v.we;
    addr_in = v.addr;
    data_in = v.data;
    tick();
    req_in = 1'b0;
    if (!v.we) begin
      check({name, " valid_at_sample"}, valid_out, 1'b0);
      for (int k = 1; k < L; k++) begin
        tick();
        check({name, " valid_early"}, valid_out, 1'b0);
      end
      tick();
      check({name, " valid_beat"}, valid_out, 1'b1);
      check({name, " data"}, data_out, v.exp);
      tick();
      check({name, " valid_after"}, valid_out, 1'b0);
      check({name, " data_held"}, data_out, v.exp);
    end
  endtask

  initial begin
    int   busy_cnt;
    logic saw_done;
    vec_t v;
    logic [7:0][8:0] e;

    n_checks = 0;
    n_fail   = 0;
    rst_in   = 1'b1;
    init_in  = 1'b0;
    req_in   = 1'b0;
    we_in    = 1'b0;
    addr_in  = '0;
    data_in  = '0;

    // Table: reads after init, write/read latency, out-of-range lane 3.
    tbl[0].we = 1'b0; tbl[0].addr = all_addr(0, 0);     tbl[0].data = '0; tbl[0].exp = init_word();
    tbl[1].we = 1'b0; tbl[1].addr = all_addr(D-1, 5);   tbl[1].data = '0; tbl[1].exp = init_word();
    tbl[2].we = 1'b1; tbl[2].addr[0] = '0;
    for (int i = 0; i < 8; i++) begin
      tbl[2].addr[i+1] = AW'(500 + i);
      tbl[2].data[i]   = 9'(100 + i);
    end
    tbl[2].exp = '0;
    tbl[3].we = 1'b0; tbl[3].addr = tbl[2].addr; tbl[3].data = '0; tbl[3].exp = tbl[2].data;
    tbl[4].we = 1'b1; tbl[4].addr = all_addr(600, 123);
    tbl[4].addr[4] = AW'(D);
    for (int i = 0; i < 8; i++) tbl[4].data[i] = 9'(200 + i);
    tbl[4].exp = '0;
    tbl[5].we = 1'b0; tbl[5].addr = tbl[4].addr; tbl[5].addr[0] = '0; tbl[5].data = '0;
    tbl[5].exp = tbl[4].data; tbl[5].exp[3] = 9'd0;
    tbl[6].we = 1'b0; tbl[6].addr = all_addr(600, 77); tbl[6].data = '0;
    tbl[6].exp = tbl[4].data; tbl[6].exp[3] = 9'd57;
    tbl[7].we = 1'b0; tbl[7].addr = all_addr(D-1, D);  tbl[7].data = '0; tbl[7].exp = init_word();

    tick();
    tick();
    rst_in = 1'b0;
    check("reset valid_out", valid_out, 1'b0);
    check("reset data_out", data_out, '0);
    check("reset busy_out", busy_out, 1'b0);
    check("reset init_done_out", init_done_out, 1'b0);

    // Full init fill: count busy cycles, bounded.
    init_in = 1'b1;
    tick();
    init_in  = 1'b0;
    busy_cnt = busy_out ? 1 : 0;
    saw_done = 1'b0;
    for (int c = 0; c < 40000 && busy_out; c++) begin
      tick();
      if (init_done_out && busy_out) saw_done = 1'b1;
      if (busy_out) busy_cnt++;
    end
    check("init busy_cycles", 72'(busy_cnt), 72'(D));
    check("init done_early", saw_done, 1'b0);
    check("init done_pulse", init_done_out, 1'b1);
    tick();
    check("init done_one_cycle", init_done_out, 1'b0);

    for (int t = 0; t < 8; t++) apply(tbl[t], $sformatf("vec%0d", t));

    // Streaming: ten writes, then ten back-to-back reads.
    for (int k = 0; k < 10; k++) begin
      v.we = 1'b1;
      v.addr = all_addr(700 + k, 0);
      for (int i = 0; i < 8; i++) v.data[i] = 9'(300 + 8*k + i);
      v.exp = '0;
      apply(v, "stream_wr");
    end
    for (int j = 0; j < 10 + L + 1; j++) begin
      if (j < 10) begin
        req_in  = 1'b1;
        we_in   = 1'b0;
        addr_in = all_addr(700 + j, 0);
      end else begin
        req_in = 1'b0;
      end
      tick();
      if (j >= L && j < 10 + L) begin
        for (int i = 0; i < 8; i++) e[i] = 9'(300 + 8*(j-L) + i);
        check($sformatf("stream valid%0d", j-L), valid_out, 1'b1);
        check($sformatf("stream data%0d", j-L), data_out, e);
      end else begin
        check($sformatf("stream idle%0d", j), valid_out, 1'b0);
      end
    end

    // Reset mid-INIT at cnt = 1000.
    v.we = 1'b1; v.addr = all_addr(999, 0);
    for (int i = 0; i < 8; i++) v.data[i] = 9'(400 + i);
    apply(v, "pre999");
    v.addr = all_addr(1000, 0);
    for (int i = 0; i < 8; i++) v.data[i] = 9'(450 + i);
    apply(v, "pre1000");
    init_in = 1'b1;
    tick();
    init_in = 1'b0;
    check("abort busy_rise", busy_out, 1'b1);
    repeat (1000) tick();
    check("abort busy_before_rst", busy_out, 1'b1);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    check("abort busy_fall", busy_out, 1'b0);
    saw_done = init_done_out;
    for (int c = 0; c < 5; c++) begin
      tick();
      saw_done = saw_done | init_done_out;
    end
    check("abort no_done", saw_done, 1'b0);
    v.we = 1'b0; v.addr = all_addr(999, 0); v.data = '0; v.exp = init_word();
    apply(v, "abort addr999");
    v.addr = all_addr(1000, 0);
    for (int i = 0; i < 8; i++) v.exp[i] = 9'(450 + i);
    apply(v, "abort addr1000");

    // Init during SERVE: in-flight read still lands; requests in INIT are ignored.
    req_in  = 1'b1;
    we_in   = 1'b0;
    addr_in = all_addr(999, 0);
    tick();
    req_in  = 1'b0;
    init_in = 1'b1;
    tick();
    init_in = 1'b0;
    check("reinit busy_rise", busy_out, 1'b1);
    check("reinit valid_early", valid_out, 1'b0);
    req_in  = 1'b1;
    addr_in = all_addr(1000, 0);
    tick();
    check("reinit inflight_valid", valid_out, 1'b1);
    check("reinit inflight_data", data_out, init_word());
    saw_done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      we_in = c[0];
      tick();
      saw_done = saw_done | valid_out;
    end
    req_in = 1'b0;
    check("reinit no_valid_in_init", saw_done, 1'b0);
    check("reinit busy_held", busy_out, 1'b1);
    check("reinit data_held", data_out, init_word());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
